// File: rtl/rto_pkg.sv
// Shared types and constants for the RTO timestamp scheduler.
// Field positions match the default 128-bit command FIFO word.
package rto_pkg;

  localparam int TS_WIDTH_D       = 64;
  localparam int DATA_WIDTH_D     = 64;
  localparam int LATE_CNT_WIDTH_D = 16;
  localparam int TS_MSB           = 127;
  localparam int TS_LSB           = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLUSH
  } state_t;

  function automatic logic [LATE_CNT_WIDTH_D-1:0] sat_inc16(
    input logic [LATE_CNT_WIDTH_D-1:0] v
  );
    return (&v) ? v : v + LATE_CNT_WIDTH_D'(1);
  endfunction

endpackage

// File: rtl/rto_timestamp_counter.sv
// Free-running timestamp counter with run gate and clear.
// Clear wins over run; the count wraps naturally at all-ones.
module rto_timestamp_counter
  import rto_pkg::*;
#(
  parameter int WIDTH = TS_WIDTH_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rto_scheduler.sv
// Holds one FIFO entry and releases its payload when the
// timestamp counter matches; late entries are dropped and counted.
module rto_scheduler
  import rto_pkg::*;
#(
  parameter int TS_WIDTH       = TS_WIDTH_D,
  parameter int DATA_WIDTH     = DATA_WIDTH_D,
  parameter int FIFO_WIDTH     = TS_WIDTH + DATA_WIDTH,
  parameter int LATE_CNT_WIDTH = LATE_CNT_WIDTH_D
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      run,
  input  logic                      counter_clear,
  input  logic [FIFO_WIDTH-1:0]     fifo_dout,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  output logic                      rto_out_valid,
  output logic [DATA_WIDTH-1:0]     rto_out_data,
  output logic [TS_WIDTH-1:0]       counter,
  output logic                      busy,
  output logic                      late_error,
  output logic [LATE_CNT_WIDTH-1:0] late_count
);

  state_t                state;
  state_t                state_n;
  logic [TS_WIDTH-1:0]   hold_ts;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  load;
  logic                  hit;
  logic                  late;
  logic                  clr;

  logic [TS_WIDTH-1:0]   head_ts;
  logic [DATA_WIDTH-1:0] head_data;

  assign head_ts   = fifo_dout[FIFO_WIDTH-1 -: TS_WIDTH];
  assign head_data = fifo_dout[DATA_WIDTH-1:0];

  rto_timestamp_counter #(
    .WIDTH(TS_WIDTH)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .clear(counter_clear),
    .count(counter)
  );

  // Reset gates the pop so a reset mid-WAIT never consumes an entry.
  always_comb begin
    state_n    = state;
    fifo_rd_en = 1'b0;
    load       = 1'b0;
    hit        = 1'b0;
    late       = 1'b0;
    clr        = 1'b0;
    if (!reset) begin
      if (flush && state != FLUSH) begin
        state_n = FLUSH;
        clr     = 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (!fifo_empty && !flush) begin
              fifo_rd_en = 1'b1;
              load       = 1'b1;
              state_n    = WAIT;
            end
          end
          WAIT: begin
            if (counter == hold_ts) begin
              hit     = 1'b1;
              state_n = IDLE;
            end else if (counter > hold_ts) begin
              late    = 1'b1;
              state_n = IDLE;
            end
          end
          FLUSH: begin
            clr        = 1'b1;
            fifo_rd_en = !fifo_empty;
            if (fifo_empty) begin
              state_n = IDLE;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      hold_ts       <= '0;
      hold_data     <= '0;
      rto_out_valid <= 1'b0;
      rto_out_data  <= '0;
      late_error    <= 1'b0;
      late_count    <= '0;
    end else begin
      state         <= state_n;
      rto_out_valid <= hit;
      if (hit) begin
        rto_out_data <= hold_data;
      end
      if (clr) begin
        hold_ts    <= '0;
        hold_data  <= '0;
        late_error <= 1'b0;
        late_count <= '0;
      end else begin
        if (load) begin
          hold_ts   <= head_ts;
          hold_data <= head_data;
        end
        if (late) begin
          late_error <= 1'b1;
          if (!(&late_count)) begin
            late_count <= late_count + LATE_CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rto_scheduler.sv
// Directed bench for rto_scheduler with an FWFT FIFO model.
// A second narrow instance covers counter wrap.
module tb_rto_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         run = 1'b0;
  logic         counter_clear = 1'b0;
  logic [127:0] fifo_dout = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd_en;
  logic         rto_out_valid;
  logic [63:0]  rto_out_data;
  logic [63:0]  counter;
  logic         busy;
  logic         late_error;
  logic [15:0]  late_count;

  logic         s_reset = 1'b1;
  logic         s_run = 1'b0;
  logic [11:0]  s_dout = '0;
  logic         s_empty = 1'b1;
  logic         s_rd_en;
  logic         s_valid;
  logic [7:0]   s_data;
  logic [3:0]   s_counter;
  logic         s_busy;
  logic         s_late_error;
  logic [3:0]   s_late_count;

  logic [127:0] q[$];
  logic [63:0]  sc[$];
  logic [63:0]  sd[$];
  int tests = 0;
  int fails = 0;
  int pops = 0;
  int bad_pops = 0;
  int consec = 0;
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

  rto_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .run          (run),
    .counter_clear(counter_clear),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .rto_out_valid(rto_out_valid),
    .rto_out_data (rto_out_data),
    .counter      (counter),
    .busy         (busy),
    .late_error   (late_error),
    .late_count   (late_count)
  );

  rto_scheduler #(
    .TS_WIDTH      (4),
    .DATA_WIDTH    (8),
    .LATE_CNT_WIDTH(4)
  ) dut_small (
    .clk          (clk),
    .reset        (s_reset),
    .flush        (1'b0),
    .run          (s_run),
    .counter_clear(1'b0),
    .fifo_dout    (s_dout),
    .fifo_empty   (s_empty),
    .fifo_rd_en   (s_rd_en),
    .rto_out_valid(s_valid),
    .rto_out_data (s_data),
    .counter      (s_counter),
    .busy         (s_busy),
    .late_error   (s_late_error),
    .late_count   (s_late_count)
  );

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_empty) bad_pops++;
    if (fifo_rd_en && q.size() > 0) begin
      void'(q.pop_front());
      pops++;
    end
  end

  always @(negedge clk) begin
    fifo_empty = (q.size() == 0);
    fifo_dout  = (q.size() > 0) ? q[0] : '0;
    if (rto_out_valid) begin
      sc.push_back(counter);
      sd.push_back(rto_out_data);
      if (prev_v) consec++;
    end
    prev_v = rto_out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] ts, input logic [63:0] d);
    q.push_back({ts, d});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    flush = 1'b0;
    counter_clear = 1'b0;
    q.delete();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int p0;
    logic rd_seen;
    do_reset();
    push(64'd500, 64'h11);
    push(64'd600, 64'h22);
    run = 1'b1;
    repeat (4) tick();
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL reset_pre_busy got %0b want 1", busy);
    end
    p0 = pops;
    rd_seen = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      tick();
      rd_seen = rd_seen | fifo_rd_en;
    end
    tests++;
    if (rd_seen !== 1'b0 || pops != p0) begin
      fails++; $display("FAIL reset_no_pop rd=%0b pops=%0d want 0", rd_seen, pops - p0);
    end
    tests++;
    if (rto_out_valid !== 1'b0 || rto_out_data !== 64'd0) begin
      fails++; $display("FAIL reset_out got v=%0b d=%h want 0", rto_out_valid, rto_out_data);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy got %0b want 0", busy);
    end
    tests++;
    if (late_error !== 1'b0 || late_count !== 16'd0) begin
      fails++; $display("FAIL reset_late got %0b/%0d want 0/0", late_error, late_count);
    end
    tests++;
    if (counter !== 64'd0) begin
      fails++; $display("FAIL reset_counter got %0d want 0", counter);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int p0;
    int s0;
    do_reset();
    p0 = pops;
    s0 = sc.size();
    push(64'd100, 64'hA5);
    run = 1'b1;
    for (int i = 0; i < 200 && sc.size() == s0; i++) tick();
    repeat (5) tick();
    tests++;
    if (sc.size() - s0 != 1) begin
      fails++; $display("FAIL single_count got %0d want 1", sc.size() - s0);
    end else begin
      tests++;
      if (sc[s0] !== 64'd101 || sd[s0] !== 64'hA5) begin
        fails++; $display("FAIL single_release got ctr=%0d d=%h want 101/a5", sc[s0], sd[s0]);
      end
    end
    tests++;
    if (pops - p0 != 1) begin
      fails++; $display("FAIL single_pops got %0d want 1", pops - p0);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    do_reset();
    s0 = sc.size();
    push(64'd50, 64'd1);
    push(64'd52, 64'd2);
    push(64'd53, 64'd3);
    repeat (3) tick();
    run = 1'b1;
    for (int i = 0; i < 150 && !(late_count == 16'd1 && sc.size() >= s0 + 2); i++) tick();
    repeat (3) tick();
    tests++;
    if (sc.size() - s0 != 2) begin
      fails++; $display("FAIL b2b_count got %0d want 2", sc.size() - s0);
    end else begin
      tests++;
      if (sc[s0] !== 64'd51 || sd[s0] !== 64'd1) begin
        fails++; $display("FAIL b2b_first got %0d/%0d want 51/1", sc[s0], sd[s0]);
      end
      tests++;
      if (sc[s0+1] !== 64'd53 || sd[s0+1] !== 64'd2) begin
        fails++; $display("FAIL b2b_second got %0d/%0d want 53/2", sc[s0+1], sd[s0+1]);
      end
    end
    tests++;
    if (late_error !== 1'b1 || late_count !== 16'd1) begin
      fails++; $display("FAIL b2b_late got %0b/%0d want 1/1", late_error, late_count);
    end
  endtask

  task automatic test_late();
    int s0;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 300 && counter < 64'd200; i++) tick();
    s0 = sc.size();
    push(64'd150, 64'h77);
    push(64'd300, 64'hBE);
    for (int i = 0; i < 200 && sc.size() == s0; i++) tick();
    repeat (3) tick();
    tests++;
    if (late_error !== 1'b1 || late_count !== 16'd1) begin
      fails++; $display("FAIL late_flag got %0b/%0d want 1/1", late_error, late_count);
    end
    tests++;
    if (sc.size() - s0 != 1) begin
      fails++; $display("FAIL late_count_strobes got %0d want 1", sc.size() - s0);
    end else begin
      tests++;
      if (sc[s0] !== 64'd301 || sd[s0] !== 64'hBE) begin
        fails++; $display("FAIL late_next got %0d/%h want 301/be", sc[s0], sd[s0]);
      end
    end
  endtask

  task automatic test_flush();
    int p0;
    int s0;
    do_reset();
    run = 1'b1;
    repeat (20) tick();
    run = 1'b0;
    push(64'd5, 64'h55);
    repeat (4) tick();
    tests++;
    if (late_count !== 16'd1) begin
      fails++; $display("FAIL flush_setup got %0d want 1", late_count);
    end
    p0 = pops;
    s0 = sc.size();
    for (int i = 0; i < 5; i++) push(64'd1000 + 64'(i), 64'(i));
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL flush_busy got %0b want 1", busy);
    end
    for (int i = 0; i < 20 && busy; i++) tick();
    repeat (2) tick();
    tests++;
    if (pops - p0 != 5 || bad_pops != 0) begin
      fails++; $display("FAIL flush_pops got %0d bad=%0d want 5/0", pops - p0, bad_pops);
    end
    tests++;
    if (sc.size() != s0) begin
      fails++; $display("FAIL flush_strobe got %0d want 0", sc.size() - s0);
    end
    tests++;
    if (late_error !== 1'b0 || late_count !== 16'd0) begin
      fails++; $display("FAIL flush_clear got %0b/%0d want 0/0", late_error, late_count);
    end
    tests++;
    if (busy !== 1'b0 || q.size() != 0) begin
      fails++; $display("FAIL flush_idle got busy=%0b q=%0d want 0/0", busy, q.size());
    end
  endtask

  task automatic test_counter();
    int s0;
    do_reset();
    s0 = sc.size();
    push(64'd10, 64'h10);
    repeat (100) tick();
    tests++;
    if (sc.size() != s0 || busy !== 1'b1 || counter !== 64'd0) begin
      fails++; $display("FAIL ctr_hold got strobes=%0d busy=%0b ctr=%0d want 0/1/0", sc.size() - s0, busy, counter);
    end
    run = 1'b1;
    repeat (5) tick();
    tests++;
    if (counter !== 64'd5) begin
      fails++; $display("FAIL ctr_run got %0d want 5", counter);
    end
    counter_clear = 1'b1;
    tick();
    counter_clear = 1'b0;
    run = 1'b0;
    tests++;
    if (counter !== 64'd0) begin
      fails++; $display("FAIL ctr_clear got %0d want 0", counter);
    end
  endtask

  task automatic test_wrap();
    s_reset = 1'b1;
    repeat (2) tick();
    s_reset = 1'b0;
    s_run = 1'b1;
    repeat (14) tick();
    tests++;
    if (s_counter !== 4'd14) begin
      fails++; $display("FAIL wrap_pre got %0d want 14", s_counter);
    end
    repeat (2) tick();
    tests++;
    if (s_counter !== 4'd0) begin
      fails++; $display("FAIL wrap_zero got %0d want 0", s_counter);
    end
    s_run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_late();
    test_flush();
    test_counter();
    test_wrap();
    tests++;
    if (consec != 0) begin
      fails++; $display("FAIL strobe_consecutive got %0d want 0", consec);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
